// File: rtl/lsu_pkg.sv
// Shared types and constants for the data-side load/store bus master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lsu_pkg;

    // Access sequencing: wait for a request, run one bus cycle, retire.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_t;

    // Access size as carried in funct3[1:0]; 2'b11 is treated as a word.
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    // Cycles allowed in BUS before the access is abandoned.
    localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/lsu_bus_master_if.sv
// Wishbone classic bus between the LSU (master) and the data-side slave.
// Latency: n/a (wires only).
// Backpressure: the slave stretches a cycle by withholding wb_ack_i/wb_err_i.
// Ports: cyc/stb/we/adr/dat_o/sel driven by master; dat_i/ack/err by slave.
interface lsu_bus_master_if;

    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: byte enables, store replication, load extension, misalignment.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
// Ports: fun3/offset/wdata/rdata_raw in; sel/dat_o/rdata_ext/misaligned out.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  fun3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  sel,
    output logic [31:0] dat_o,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [31:0] shifted;

    always_comb begin
        sel        = 4'b1111;
        dat_o      = wdata;
        misaligned = 1'b0;
        rdata_ext  = '0;
        // Move the addressed lane down to bit 0 before extending.
        shifted    = rdata_raw >> {offset, 3'b000};

        case (fun3[1:0])
            SIZE_B: begin
                sel       = 4'b0001 << offset;
                dat_o     = {4{wdata[7:0]}};
                rdata_ext = fun3[2] ? {24'b0, shifted[7:0]}
                                    : {{24{shifted[7]}}, shifted[7:0]};
            end
            SIZE_H: begin
                sel        = 4'b0011 << {offset[1], 1'b0};
                dat_o      = {2{wdata[15:0]}};
                misaligned = offset[0];
                rdata_ext  = fun3[2] ? {16'b0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
            end
            default: begin
                sel        = 4'b1111;
                dat_o      = wdata;
                misaligned = |offset;
                rdata_ext  = rdata_raw;
            end
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// MEM-stage load/store master: one Wishbone classic cycle per aligned request.
// Latency: request cycle + (1 + wait states) bus cycles + 1 retire cycle.
// Backpressure: holds stall_pipl until the slave terminates or the timeout fires.
// Ports: clk/reset_n; MEM-stage request and load result; stall/exception/error
// flags to the control unit; Wishbone master side through lsu_bus_master_if.
module lsu_bus_master
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               mem_read_mem,
    input  logic               mem_write_mem,
    input  logic [2:0]         fun3_mem,
    input  logic [31:0]        addr_mem,
    input  logic [31:0]        wdata_mem,
    output logic [31:0]        rdata_mem,
    output logic               stall_pipl,
    output logic               misaligned_exc,
    output logic               bus_err,
    lsu_bus_master_if.master   wb
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    lsu_state_t  state, state_nxt;
    logic [7:0]  cnt;
    logic [2:0]  fun3_q;
    logic [1:0]  off_q;

    logic        req;
    logic        start;
    logic        bus_done;
    logic        bus_fail;
    logic [2:0]  align_fun3;
    logic [1:0]  align_off;
    logic [3:0]  align_sel;
    logic [31:0] align_dat;
    logic [31:0] align_rdata;
    logic        align_mis;

    assign req = mem_read_mem | mem_write_mem;

    // One aligner serves both phases: live request fields while idle (lanes,
    // store data, misalignment), the captured fields in BUS (load extension).
    assign align_fun3 = (state == ST_IDLE) ? fun3_mem       : fun3_q;
    assign align_off  = (state == ST_IDLE) ? addr_mem[1:0]  : off_q;

    lsu_align u_align (
        .fun3       (align_fun3),
        .offset     (align_off),
        .wdata      (wdata_mem),
        .rdata_raw  (wb.wb_dat_i),
        .sel        (align_sel),
        .dat_o      (align_dat),
        .rdata_ext  (align_rdata),
        .misaligned (align_mis)
    );

    // Error beats a simultaneous ack; the counter reaching TIMEOUT counts as error.
    assign bus_fail = wb.wb_err_i | (cnt == TIMEOUT_CNT);
    assign bus_done = wb.wb_ack_i | bus_fail;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        start          = 1'b0;
        stall_pipl     = 1'b0;
        misaligned_exc = 1'b0;
        case (state)
            ST_IDLE: begin
                misaligned_exc = req & align_mis;
                start          = req & ~align_mis;
                stall_pipl     = start;
                if (start) begin
                    state_nxt = ST_BUS;
                end
            end
            ST_BUS: begin
                stall_pipl = 1'b1;
                if (bus_done) begin
                    state_nxt = ST_DONE;
                end
            end
            // The request still visible here belongs to the retiring instruction.
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wb.wb_cyc_o <= 1'b0;
            wb.wb_stb_o <= 1'b0;
            wb.wb_we_o  <= 1'b0;
            wb.wb_adr_o <= '0;
            wb.wb_dat_o <= '0;
            wb.wb_sel_o <= '0;
            rdata_mem   <= '0;
            bus_err     <= 1'b0;
            cnt         <= '0;
            fun3_q      <= '0;
            off_q       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bus_err <= 1'b0;
                    if (start) begin
                        wb.wb_cyc_o <= 1'b1;
                        wb.wb_stb_o <= 1'b1;
                        wb.wb_we_o  <= mem_write_mem;   // store wins over load
                        wb.wb_adr_o <= {addr_mem[31:2], 2'b00};
                        wb.wb_dat_o <= align_dat;
                        wb.wb_sel_o <= align_sel;
                        fun3_q      <= fun3_mem;
                        off_q       <= addr_mem[1:0];
                        cnt         <= '0;
                    end
                end
                ST_BUS: begin
                    if (bus_done) begin
                        wb.wb_cyc_o <= 1'b0;
                        wb.wb_stb_o <= 1'b0;
                        wb.wb_we_o  <= 1'b0;
                        if (bus_fail) begin
                            rdata_mem <= '0;
                            bus_err   <= 1'b1;
                        end else if (!wb.wb_we_o) begin
                            rdata_mem <= align_rdata;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: bus_err <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Self-checking bench for lsu_bus_master: directed scenarios plus random accesses
// compared against an arithmetic model of lane selection and load extension.
module tb_lsu_bus_master;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_read_mem;
    logic        mem_write_mem;
    logic [2:0]  fun3_mem;
    logic [31:0] addr_mem;
    logic [31:0] wdata_mem;
    logic [31:0] rdata_mem;
    logic        stall_pipl;
    logic        misaligned_exc;
    logic        bus_err;

    int errors = 0;
    int checks = 0;
    int cyc_no = 0;

    lsu_bus_master_if wb ();

    lsu_bus_master #(.TIMEOUT(TO)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .mem_read_mem   (mem_read_mem),
        .mem_write_mem  (mem_write_mem),
        .fun3_mem       (fun3_mem),
        .addr_mem       (addr_mem),
        .wdata_mem      (wdata_mem),
        .rdata_mem      (rdata_mem),
        .stall_pipl     (stall_pipl),
        .misaligned_exc (misaligned_exc),
        .bus_err        (bus_err),
        .wb             (wb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_no <= cyc_no + 1;

    // ---------------- reference model ----------------
    function automatic bit m_mis(input logic [2:0] f3, input logic [31:0] a);
        if (f3 % 4 == 0) return 1'b0;
        if (f3 % 4 == 1) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    function automatic logic [3:0] m_sel(input logic [2:0] f3, input logic [31:0] a);
        int off;
        off = int'(a % 4);
        if (f3 % 4 == 0) return 4'(1 << off);
        if (f3 % 4 == 1) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdat(input logic [2:0] f3, input logic [31:0] w);
        if (f3 % 4 == 0) return (w & 32'hFF) * 32'h0101_0101;
        if (f3 % 4 == 1) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] r);
        logic [31:0] v;
        bit          uns;
        uns = (f3 >= 4);
        v   = r >> (8 * (a % 4));
        if (f3 % 4 == 0) begin
            v = v & 32'hFF;
            if (!uns && v >= 128) v = v - 256;
        end else if (f3 % 4 == 1) begin
            v = v & 32'hFFFF;
            if (!uns && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    // ---------------- generic access driver ----------------
    // term: 0 ack, 1 err, 2 ack+err together, 3 no termination (timeout)
    task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] w,
                          input logic [31:0] rdat, input int wt, input int term,
                          input string name, output int first_cyc, output int last_cyc);
        int stall_cnt;
        int bus_cnt;
        int exp_bus;
        bit done;
        stall_cnt = 0;
        bus_cnt   = 0;
        done      = 1'b0;
        first_cyc = -1;
        last_cyc  = -1;
        exp_bus   = (term == 3) ? TO + 1 : wt + 1;

        mem_read_mem  = rd;
        mem_write_mem = wr;
        fun3_mem      = f3;
        addr_mem      = a;
        wdata_mem     = w;
        wb.wb_dat_i   = rdat;
        #1;
        checks++;
        if (stall_pipl !== 1'b1 || misaligned_exc !== 1'b0)
            $display("FAIL %s req: stall=%b mis=%b want stall=1 mis=0", name, stall_pipl, misaligned_exc);
        if (stall_pipl === 1'b1) stall_cnt++;

        for (int k = 0; k < 600 && !done; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (wb.wb_cyc_o === 1'b1) begin
                bus_cnt++;
                if (first_cyc < 0) first_cyc = cyc_no;
                last_cyc = cyc_no;
                if (stall_pipl === 1'b1) stall_cnt++;
                checks++;
                if (wb.wb_adr_o !== (a & ~32'h3)) begin
                    errors++;
                    $display("FAIL %s adr: got %h want %h", name, wb.wb_adr_o, a & ~32'h3);
                end
                checks++;
                if (wb.wb_sel_o !== m_sel(f3, a)) begin
                    errors++;
                    $display("FAIL %s sel: got %b want %b", name, wb.wb_sel_o, m_sel(f3, a));
                end
                checks++;
                if (wb.wb_we_o !== wr || wb.wb_stb_o !== 1'b1) begin
                    errors++;
                    $display("FAIL %s we/stb: got %b/%b want %b/1", name, wb.wb_we_o, wb.wb_stb_o, wr);
                end
                if (wr) begin
                    checks++;
                    if (wb.wb_dat_o !== m_wdat(f3, w)) begin
                        errors++;
                        $display("FAIL %s dat_o: got %h want %h", name, wb.wb_dat_o, m_wdat(f3, w));
                    end
                end
                if (term != 3 && bus_cnt == wt + 1) begin
                    wb.wb_ack_i = (term == 0 || term == 2);
                    wb.wb_err_i = (term == 1 || term == 2);
                end else begin
                    wb.wb_ack_i = 1'b0;
                    wb.wb_err_i = 1'b0;
                end
            end else begin
                wb.wb_ack_i = 1'b0;
                wb.wb_err_i = 1'b0;
                done = 1'b1;
                checks++;
                if (stall_pipl !== 1'b0 || wb.wb_stb_o !== 1'b0 || wb.wb_we_o !== 1'b0) begin
                    errors++;
                    $display("FAIL %s done_ctl: stall=%b stb=%b we=%b want 0", name,
                             stall_pipl, wb.wb_stb_o, wb.wb_we_o);
                end
                checks++;
                if (bus_err !== (term != 0)) begin
                    errors++;
                    $display("FAIL %s bus_err: got %b want %b", name, bus_err, term != 0);
                end
                if (term != 0) begin
                    checks++;
                    if (rdata_mem !== 32'h0) begin
                        errors++;
                        $display("FAIL %s rdata_err: got %h want 0", name, rdata_mem);
                    end
                end else if (rd && !wr) begin
                    checks++;
                    if (rdata_mem !== m_load(f3, a, rdat)) begin
                        errors++;
                        $display("FAIL %s rdata: got %h want %h", name, rdata_mem, m_load(f3, a, rdat));
                    end
                end
            end
        end
        mem_read_mem  = 1'b0;
        mem_write_mem = 1'b0;

        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s termination: access never completed, want completion", name);
        end
        checks++;
        if (bus_cnt != exp_bus || stall_cnt != exp_bus + 1) begin
            errors++;
            $display("FAIL %s cycles: cyc=%0d stall=%0d want cyc=%0d stall=%0d", name,
                     bus_cnt, stall_cnt, exp_bus, exp_bus + 1);
        end

        // Following cycle is IDLE: error pulse gone, bus quiet.
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus_err !== 1'b0 || wb.wb_cyc_o !== 1'b0 || stall_pipl !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after: err=%b cyc=%b stall=%b want 0", name,
                     bus_err, wb.wb_cyc_o, stall_pipl);
        end
    endtask

    task automatic mis_check(input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [31:0] a, input string name);
        mem_read_mem  = rd;
        mem_write_mem = wr;
        fun3_mem      = f3;
        addr_mem      = a;
        wdata_mem     = $urandom;
        #1;
        checks++;
        if (misaligned_exc !== 1'b1 || stall_pipl !== 1'b0) begin
            errors++;
            $display("FAIL %s mis: exc=%b stall=%b want 1/0", name, misaligned_exc, stall_pipl);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (wb.wb_cyc_o !== 1'b0 || misaligned_exc !== 1'b1) begin
                errors++;
                $display("FAIL %s mis_hold: cyc=%b exc=%b want 0/1", name, wb.wb_cyc_o, misaligned_exc);
            end
        end
        mem_read_mem  = 1'b0;
        mem_write_mem = 1'b0;
        #1;
        checks++;
        if (misaligned_exc !== 1'b0) begin
            errors++;
            $display("FAIL %s mis_clear: exc=%b want 0", name, misaligned_exc);
        end
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (wb.wb_cyc_o !== 1'b0 || wb.wb_stb_o !== 1'b0 || wb.wb_we_o !== 1'b0 ||
            wb.wb_adr_o !== 32'h0 || wb.wb_dat_o !== 32'h0 || wb.wb_sel_o !== 4'h0 ||
            rdata_mem !== 32'h0 || bus_err !== 1'b0 || stall_pipl !== 1'b0 ||
            misaligned_exc !== 1'b0) begin
            errors++;
            $display("FAIL reset: cyc=%b adr=%h sel=%b rdata=%h err=%b stall=%b want all 0",
                     wb.wb_cyc_o, wb.wb_adr_o, wb.wb_sel_o, rdata_mem, bus_err, stall_pipl);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lb_sign();
        int f, l;
        access(1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_FF12, 0, 0, "lb_sign", f, l);
        checks++;
        if (m_load(3'b000, 32'h1003, 32'h80FF_FF12) !== 32'hFFFF_FF80 || dut.rdata_mem !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL lb_const: got %h want ffffff80", rdata_mem);
        end
    endtask

    task automatic test_sh_wait();
        int f, l;
        access(0, 1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 3, 0, "sh_wait", f, l);
    endtask

    task automatic test_misaligned();
        mis_check(1, 0, 3'b010, 32'h0000_0001, "lw_mis");
        mis_check(0, 1, 3'b001, 32'h0000_0103, "sh_mis");
    endtask

    task automatic test_timeout();
        int f, l;
        access(0, 1, 3'b010, 32'h0000_3000, 32'h1234_5678, 32'h0, 0, 3, "timeout", f, l);
    endtask

    task automatic test_ack_err_reset();
        int f, l;
        access(1, 0, 3'b010, 32'h0000_4004, 32'h0, 32'hDEAD_BEEF, 1, 2, "ack_err", f, l);
        // New access, reset during its second BUS cycle.
        mem_read_mem = 1'b1;
        fun3_mem     = 3'b010;
        addr_mem     = 32'h0000_0020;
        wb.wb_dat_i  = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (wb.wb_cyc_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_bus_start: cyc=%b want 1", wb.wb_cyc_o);
        end
        @(posedge clk);
        @(negedge clk);
        reset_n      = 1'b0;
        mem_read_mem = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (wb.wb_cyc_o !== 1'b0 || wb.wb_stb_o !== 1'b0 || wb.wb_we_o !== 1'b0 ||
            wb.wb_adr_o !== 32'h0 || wb.wb_sel_o !== 4'h0 || rdata_mem !== 32'h0 ||
            bus_err !== 1'b0 || stall_pipl !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: cyc=%b adr=%h sel=%b rdata=%h err=%b stall=%b want 0",
                     wb.wb_cyc_o, wb.wb_adr_o, wb.wb_sel_o, rdata_mem, bus_err, stall_pipl);
        end
        reset_n     = 1'b1;
        wb.wb_ack_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wb.wb_ack_i = 1'b0;
        checks++;
        if (wb.wb_cyc_o !== 1'b0 || rdata_mem !== 32'h0 || bus_err !== 1'b0 || stall_pipl !== 1'b0) begin
            errors++;
            $display("FAIL late_ack: cyc=%b rdata=%h err=%b stall=%b want 0",
                     wb.wb_cyc_o, rdata_mem, bus_err, stall_pipl);
        end
    endtask

    task automatic test_back_to_back();
        int f1, l1, f2, l2;
        access(1, 0, 3'b010, 32'h0000_0010, 32'h0, $urandom, 0, 0, "b2b_lw", f1, l1);
        access(1, 0, 3'b101, 32'h0000_0016, 32'h0, 32'h8001_0000, 0, 0, "b2b_lhu", f2, l2);
        checks++;
        if (f2 - l1 - 1 != 2) begin
            errors++;
            $display("FAIL b2b_gap: low cycles=%0d want 2", f2 - l1 - 1);
        end
        checks++;
        if (rdata_mem !== 32'h0000_8001) begin
            errors++;
            $display("FAIL b2b_lhu_val: got %h want 00008001", rdata_mem);
        end
    endtask

    task automatic test_write_priority();
        int f, l;
        access(1, 1, 3'b000, 32'h0000_5001, 32'h0000_00A5, 32'h0, 2, 0, "rw_prio", f, l);
    endtask

    task automatic test_random();
        int f, l, kind, wt, term;
        logic [2:0]  f3;
        logic [31:0] a;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end else begin
                f3 = 3'($urandom_range(0, 2));
            end
            a    = $urandom;
            wt   = $urandom_range(0, 3);
            term = ($urandom_range(0, 9) == 0) ? 1 : 0;
            if (m_mis(f3, a))
                mis_check(kind != 1, kind != 0, f3, a, "rand_mis");
            else
                access(kind != 1, kind != 0, f3, a, $urandom, $urandom, wt, term, "rand", f, l);
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        mem_read_mem  = 1'b0;
        mem_write_mem = 1'b0;
        fun3_mem      = 3'b0;
        addr_mem      = 32'h0;
        wdata_mem     = 32'h0;
        wb.wb_dat_i   = 32'h0;
        wb.wb_ack_i   = 1'b0;
        wb.wb_err_i   = 1'b0;
        @(negedge clk);
        test_reset();
        test_lb_sign();
        test_sh_wait();
        test_misaligned();
        test_timeout();
        test_ack_err_reset();
        test_back_to_back();
        test_write_priority();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
